// File: rtl/regfile_dump_reader_if.sv
// Output word stream of the regfile dump reader: one captured register per valid/ready handshake.
// The master drives the word; the slave returns ready.
interface regfile_dump_reader_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic             out_last;

    modport master (output out_valid, out_data, out_addr, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_addr, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a contiguous, wrapping range of regfile addresses through the asynchronous read port
// and streams each captured word out over a valid/ready interface.
module regfile_dump_reader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AW-1:0]         start_addr,
    input  logic [CW-1:0]         count,
    input  logic                  abort,
    output logic [AW-1:0]         rd_addr,
    input  logic [WIDTH-1:0]      rd_data,
    regfile_dump_reader_if.master out_s,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [1:0]       state, state_nx;
    logic [AW-1:0]    addr;
    logic [CW-1:0]    rem;
    logic [WIDTH-1:0] data_q;
    logic [AW-1:0]    addr_q;
    logic             last_q;
    logic             launch;
    logic             handshake;
    logic             final_word;

    assign launch     = start && (count != '0);
    assign handshake  = out_s.out_valid && out_s.out_ready;
    assign final_word = (rem == CW'(1));

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (launch) state_nx = S_FETCH;
            S_FETCH: state_nx = abort ? S_IDLE : S_SEND;
            S_SEND: begin
                if (abort)          state_nx = S_IDLE;
                else if (handshake) state_nx = final_word ? S_DONE : S_FETCH;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // A cancelled FETCH or SEND leaves the captured word and the walk position untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            rem    <= '0;
            data_q <= '0;
            addr_q <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        addr <= start_addr;
                        rem  <= (count > DEPTH_C) ? DEPTH_C : count;
                    end
                end
                S_FETCH: begin
                    if (!abort) begin
                        data_q <= rd_data;
                        addr_q <= addr;
                        last_q <= final_word;
                    end
                end
                S_SEND: begin
                    if (!abort && handshake && !final_word) begin
                        addr <= (addr == LAST_ADDR) ? '0 : addr + AW'(1);
                        rem  <= rem - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // addr only moves on the edge into FETCH, so rd_addr holds its last value elsewhere.
    assign rd_addr         = addr;
    assign out_s.out_valid = (state == S_SEND);
    assign out_s.out_data  = data_q;
    assign out_s.out_addr  = addr_q;
    assign out_s.out_last  = last_q;
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_DONE);

endmodule
